// File: rtl/keyboard_char_ctrl.sv
// PS/2 scancode to character controller: decodes make/break/extended prefixes, tracks shift and
// language state, sequences a registered-address scancode ROM and queues characters in a FIFO.
module keyboard_char_ctrl #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] LANG_KEY   = 8'h0E,
  parameter bit         REPEAT_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic [9:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       lang,
  output logic       shift,
  output logic       overflow,
  output logic [7:0] drop_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, WAIT, CAPT} state_t;

  state_t      state, state_nxt;
  logic        lshift, rshift;
  logic [7:0]  last_key;
  logic        do_lookup, set_ls, set_rs, clr_ls, clr_rs, tog_lang, clr_last;
  logic        byte_drop, push_req;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        full, pop, push_ok, ovf;
  logic [1:0]  drop_inc;
  logic [8:0]  drop_sum;

  assign shift      = lshift | rshift;
  assign char_valid = (count != '0);
  assign char_data  = mem[rd_ptr];
  assign full       = (count == FULL_CNT);
  assign pop        = char_valid & char_ready;
  assign push_ok    = push_req & (~full | pop);
  assign ovf        = push_req & full & ~pop;
  assign drop_inc   = {1'b0, byte_drop} + {1'b0, ovf};
  assign drop_sum   = {1'b0, drop_count} + {7'b0, drop_inc};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Bytes arriving while a lookup is in flight are dropped rather than queued.
  always_comb begin
    state_nxt = state;
    do_lookup = 1'b0;
    set_ls    = 1'b0;
    set_rs    = 1'b0;
    clr_ls    = 1'b0;
    clr_rs    = 1'b0;
    tog_lang  = 1'b0;
    clr_last  = 1'b0;
    byte_drop = 1'b0;
    push_req  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_done_tick) begin
          if (rx_data == 8'hF0)                          state_nxt = BRK;
          else if (rx_data == 8'hE0)                     state_nxt = EXT;
          else if (rx_data == 8'h12)                     set_ls    = 1'b1;
          else if (rx_data == 8'h59)                     set_rs    = 1'b1;
          else if (rx_data == LANG_KEY)                  tog_lang  = 1'b1;
          else if (REPEAT_EN || (rx_data != last_key)) begin
            do_lookup = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      BRK: begin
        if (rx_done_tick) begin
          clr_ls    = (rx_data == 8'h12);
          clr_rs    = (rx_data == 8'h59);
          clr_last  = (rx_data == last_key);
          state_nxt = IDLE;
        end
      end
      EXT: begin
        if (rx_done_tick) state_nxt = (rx_data == 8'hF0) ? EXT_BRK : IDLE;
      end
      EXT_BRK: begin
        if (rx_done_tick) state_nxt = IDLE;
      end
      WAIT: begin
        byte_drop = rx_done_tick;
        state_nxt = CAPT;
      end
      CAPT: begin
        byte_drop = rx_done_tick;
        push_req  = (rom_data != 8'h00);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
      lshift   <= 1'b0;
      rshift   <= 1'b0;
      lang     <= 1'b0;
      last_key <= '0;
    end else begin
      if (do_lookup) begin
        rom_addr <= {lang, shift, rx_data};
        last_key <= rx_data;
      end else if (clr_last) begin
        last_key <= '0;
      end
      if (set_ls)        lshift <= 1'b1;
      else if (clr_ls)   lshift <= 1'b0;
      if (set_rs)        rshift <= 1'b1;
      else if (clr_rs)   rshift <= 1'b0;
      if (tog_lang)      lang   <= ~lang;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= rom_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      overflow   <= ovf;
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_keyboard_char_ctrl.sv
// Testbench for keyboard_char_ctrl: table of scancode bytes with expected address/shift/lang,
// a behavioural ROM, and a scoreboard queue of expected characters.
module tb_keyboard_char_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic [9:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic       lang;
  logic       shift;
  logic       overflow;
  logic [7:0] drop_count;

  int checks = 0;
  int failures = 0;
  int ov_pulses = 0;
  logic [7:0] sbq [$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_addr;
    logic       exp_shift;
    logic       exp_lang;
    logic [7:0] exp_char;
  } vec_t;

  vec_t vecs [35];

  keyboard_char_ctrl #(.FIFO_DEPTH(4), .LANG_KEY(8'h0E), .REPEAT_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .lang(lang), .shift(shift), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] romLookup(input logic [9:0] a);
    logic [7:0] c;
    case (a[7:0])
      8'h1C:   c = 8'h61;
      8'h15:   c = 8'h71;
      8'h1D:   c = 8'h77;
      8'h24:   c = 8'h65;
      8'h2D:   c = 8'h72;
      8'h2C:   c = 8'h74;
      default: c = 8'h00;
    endcase
    if (c != 8'h00 && a[8]) c = c - 8'h20;
    if (c != 8'h00 && a[9]) c = c | 8'h80;
    return c;
  endfunction

  always @(posedge clk) rom_data <= romLookup(rom_addr);

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every accepted character is compared against the oldest expected one.
  always @(negedge clk) begin
    if (reset_n && overflow) ov_pulses++;
    if (reset_n && char_valid && char_ready) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_char", {8'h00, char_data}, 16'hFFFF);
      end else begin
        checkOutput("char", {8'h00, char_data}, {8'h00, sbq.pop_front()});
      end
    end
  end

  task automatic sendByte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.exp_char != 8'h00) sbq.push_back(v.exp_char);
    sendByte(v.data);
    checkOutput("rom_addr", {6'h00, rom_addr}, {6'h00, v.exp_addr});
    checkOutput("shift", {15'h0, shift}, {15'h0, v.exp_shift});
    checkOutput("lang", {15'h0, lang}, {15'h0, v.exp_lang});
  endtask

  task automatic drainQueue(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 16'(sbq.size()), 16'h0);
    sbq.delete();
  endtask

  initial begin
    vecs = '{
      '{8'h1C, 10'h01C, 1'b0, 1'b0, 8'h61},
      '{8'hF0, 10'h01C, 1'b0, 1'b0, 8'h00},
      '{8'h1C, 10'h01C, 1'b0, 1'b0, 8'h00},
      '{8'h12, 10'h01C, 1'b1, 1'b0, 8'h00},
      '{8'h1C, 10'h11C, 1'b1, 1'b0, 8'h41},
      '{8'hF0, 10'h11C, 1'b1, 1'b0, 8'h00},
      '{8'h1C, 10'h11C, 1'b1, 1'b0, 8'h00},
      '{8'hF0, 10'h11C, 1'b1, 1'b0, 8'h00},
      '{8'h12, 10'h11C, 1'b0, 1'b0, 8'h00},
      '{8'h1C, 10'h01C, 1'b0, 1'b0, 8'h61},
      '{8'h0E, 10'h01C, 1'b0, 1'b1, 8'h00},
      '{8'h1C, 10'h21C, 1'b0, 1'b1, 8'hE1},
      '{8'hF0, 10'h21C, 1'b0, 1'b1, 8'h00},
      '{8'h0E, 10'h21C, 1'b0, 1'b1, 8'h00},
      '{8'h0E, 10'h21C, 1'b0, 1'b0, 8'h00},
      '{8'hE0, 10'h21C, 1'b0, 1'b0, 8'h00},
      '{8'h75, 10'h21C, 1'b0, 1'b0, 8'h00},
      '{8'hE0, 10'h21C, 1'b0, 1'b0, 8'h00},
      '{8'hF0, 10'h21C, 1'b0, 1'b0, 8'h00},
      '{8'h75, 10'h21C, 1'b0, 1'b0, 8'h00},
      '{8'h12, 10'h21C, 1'b1, 1'b0, 8'h00},
      '{8'h1C, 10'h11C, 1'b1, 1'b0, 8'h41},
      '{8'hF0, 10'h11C, 1'b1, 1'b0, 8'h00},
      '{8'h1C, 10'h11C, 1'b1, 1'b0, 8'h00},
      '{8'hF0, 10'h11C, 1'b1, 1'b0, 8'h00},
      '{8'h12, 10'h11C, 1'b0, 1'b0, 8'h00},
      '{8'h1C, 10'h01C, 1'b0, 1'b0, 8'h61},
      '{8'h1C, 10'h01C, 1'b0, 1'b0, 8'h61},
      '{8'h59, 10'h01C, 1'b1, 1'b0, 8'h00},
      '{8'h2C, 10'h12C, 1'b1, 1'b0, 8'h54},
      '{8'hF0, 10'h12C, 1'b1, 1'b0, 8'h00},
      '{8'h59, 10'h12C, 1'b0, 1'b0, 8'h00},
      '{8'h3A, 10'h03A, 1'b0, 1'b0, 8'h00},
      '{8'hE0, 10'h03A, 1'b0, 1'b0, 8'h00},
      '{8'h12, 10'h03A, 1'b0, 1'b0, 8'h00}
    };

    reset_n      = 1'b0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    char_ready   = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_rom_addr", {6'h00, rom_addr}, 16'h0);
    checkOutput("rst_char_valid", {15'h0, char_valid}, 16'h0);
    checkOutput("rst_char_data", {8'h00, char_data}, 16'h0);
    checkOutput("rst_lang", {15'h0, lang}, 16'h0);
    checkOutput("rst_shift", {15'h0, shift}, 16'h0);
    checkOutput("rst_overflow", {15'h0, overflow}, 16'h0);
    checkOutput("rst_drop_count", {8'h00, drop_count}, 16'h0);
    reset_n = 1'b1;

    // Exact latency: tick in cycle N, character visible in cycle N+3 and not before.
    sbq.push_back(8'h61);
    @(posedge clk); #1;
    rx_done_tick = 1'b1;
    rx_data      = 8'h1C;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    @(negedge clk);
    checkOutput("lat_n1_valid", {15'h0, char_valid}, 16'h0);
    checkOutput("lat_rom_addr", {6'h00, rom_addr}, 16'h01C);
    @(negedge clk);
    checkOutput("lat_n2_valid", {15'h0, char_valid}, 16'h0);
    @(negedge clk);
    checkOutput("lat_n3_valid", {15'h0, char_valid}, 16'h1);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 35; i++) applyStimulus(vecs[i]);
    drainQueue("table_drain");
    checkOutput("table_drop_count", {8'h00, drop_count}, 16'h0);

    // Fill the FIFO with the consumer stalled, overflow on the fifth key.
    char_ready = 1'b0;
    sendByte(8'h15);
    sendByte(8'h1D);
    sendByte(8'h24);
    sendByte(8'h2D);
    checkOutput("full_no_ovf", 16'(ov_pulses), 16'h0);
    sendByte(8'h2C);
    checkOutput("ovf_pulses", 16'(ov_pulses), 16'h1);
    checkOutput("ovf_drop_count", {8'h00, drop_count}, 16'h1);
    checkOutput("ovf_valid", {15'h0, char_valid}, 16'h1);
    checkOutput("ovf_head", {8'h00, char_data}, 16'h0071);
    sbq.push_back(8'h71);
    sbq.push_back(8'h77);
    sbq.push_back(8'h65);
    sbq.push_back(8'h72);
    @(posedge clk); #1;
    char_ready = 1'b1;
    drainQueue("ovf_drain");
    @(negedge clk);
    checkOutput("ovf_empty", {15'h0, char_valid}, 16'h0);

    // Second byte arrives while the lookup is waiting on the ROM.
    sbq.push_back(8'h61);
    @(posedge clk); #1;
    rx_done_tick = 1'b1;
    rx_data      = 8'h1C;
    @(posedge clk); #1;
    rx_data      = 8'h1D;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    repeat (4) @(negedge clk);
    drainQueue("wait_drain");
    checkOutput("wait_drop_count", {8'h00, drop_count}, 16'h2);
    checkOutput("wait_no_ovf", 16'(ov_pulses), 16'h1);

    // Reset asserted mid-lookup must discard the pending character.
    sendByte(8'h12);
    checkOutput("pre_rst_shift", {15'h0, shift}, 16'h1);
    @(posedge clk); #1;
    rx_done_tick = 1'b1;
    rx_data      = 8'h1C;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    reset_n      = 1'b0;
    #1;
    checkOutput("mid_rst_rom_addr", {6'h00, rom_addr}, 16'h0);
    checkOutput("mid_rst_shift", {15'h0, shift}, 16'h0);
    checkOutput("mid_rst_lang", {15'h0, lang}, 16'h0);
    checkOutput("mid_rst_valid", {15'h0, char_valid}, 16'h0);
    checkOutput("mid_rst_drop", {8'h00, drop_count}, 16'h0);
    checkOutput("mid_rst_ovf", {15'h0, overflow}, 16'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("post_rst_valid", {15'h0, char_valid}, 16'h0);
    checkOutput("post_rst_sbq", 16'(sbq.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
